// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and MDU write-backs onto the single register-file write port; ALU -> write in 1 cycle, MDU -> >=2 cycles.
// MDU results queue in a DEPTH-entry FIFO (mdu_wr_ready = !full); a starved FIFO forces a one-cycle alu_stall.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_wr_valid,
  input  logic [4:0]               alu_wr_reg,
  input  logic [31:0]              alu_wr_data,
  output logic                     alu_stall,
  input  logic                     mdu_wr_valid,
  output logic                     mdu_wr_ready,
  input  logic [4:0]               mdu_wr_reg,
  input  logic [31:0]              mdu_wr_data,
  output logic                     reg_write,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifo_reg [DEPTH];
  logic [31:0]      fifo_dat [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [SC_W-1:0]  starve_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic alu_win;
  logic push;
  logic pop;
  logic stall_next;

  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == CNT_W'(DEPTH));
  assign mdu_wr_ready = !fifo_full;

  // Writes to r0 are architecturally void, so they neither win the port nor occupy the FIFO.
  assign alu_win    = alu_wr_valid && !alu_stall && (alu_wr_reg != 5'd0);
  assign pop        = !alu_win && !fifo_empty;
  assign push       = mdu_wr_valid && !fifo_full && (mdu_wr_reg != 5'd0);
  assign stall_next = alu_win && !fifo_empty && (starve_cnt == SC_W'(STARVE_MAX - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr] <= mdu_wr_reg;
      fifo_dat[wr_ptr] <= mdu_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      alu_stall <= stall_next;
      if (fifo_empty || pop)
        starve_cnt <= '0;
      else if (alu_win)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Address/data hold their last value when idle; consumers qualify them with reg_write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else if (alu_win) begin
      reg_write  <= 1'b1;
      write_reg  <= alu_wr_reg;
      write_data <= alu_wr_data;
    end else if (pop) begin
      reg_write  <= 1'b1;
      write_reg  <= fifo_reg[rd_ptr];
      write_data <= fifo_dat[rd_ptr];
    end else begin
      reg_write  <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < fifo_count)
        pend_mask[fifo_reg[rd_ptr + PTR_W'(i)]] = 1'b1;
    end
    if (reg_write)
      pend_mask[write_reg] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_wr_valid;
  logic [4:0]  alu_wr_reg;
  logic [31:0] alu_wr_data;
  logic        alu_stall;
  logic        mdu_wr_valid;
  logic        mdu_wr_ready;
  logic [4:0]  mdu_wr_reg;
  logic [31:0] mdu_wr_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;

  int vectors;
  int miscompares;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wr_valid (alu_wr_valid),
    .alu_wr_reg   (alu_wr_reg),
    .alu_wr_data  (alu_wr_data),
    .alu_stall    (alu_stall),
    .mdu_wr_valid (mdu_wr_valid),
    .mdu_wr_ready (mdu_wr_ready),
    .mdu_wr_reg   (mdu_wr_reg),
    .mdu_wr_data  (mdu_wr_data),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pend_mask    (pend_mask),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 100000)", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wr_valid = 1'b0;
    alu_wr_reg   = 5'd0;
    alu_wr_data  = 32'd0;
    mdu_wr_valid = 1'b0;
    mdu_wr_reg   = 5'd0;
    mdu_wr_data  = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    vectors++;
    if (reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_out: got we=%b reg=%0d data=%h, want 0/0/0", reg_write, write_reg, write_data);
    end
    vectors++;
    if (alu_stall !== 1'b0 || pend_mask !== 32'd0 || mdu_wr_ready !== 1'b1 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: got stall=%b mask=%h rdy=%b cnt=%0d, want 0/0/1/0",
               alu_stall, pend_mask, mdu_wr_ready, fifo_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_write();
    alu_wr_valid = 1'b1; alu_wr_reg = 5'd5; alu_wr_data = 32'h12345678;
    tick();
    idle();
    vectors++;
    if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h12345678 || pend_mask !== 32'h20) begin
      miscompares++;
      $display("FAIL alu_write: got we=%b reg=%0d data=%h mask=%h, want 1/5/12345678/00000020",
               reg_write, write_reg, write_data, pend_mask);
    end
    tick();
    vectors++;
    if (reg_write !== 1'b0 || pend_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL alu_after: got we=%b mask=%h, want 0/00000000", reg_write, pend_mask);
    end
  endtask

  task automatic test_mdu_write();
    mdu_wr_valid = 1'b1; mdu_wr_reg = 5'd7; mdu_wr_data = 32'hDEADBEEF;
    tick();
    idle();
    vectors++;
    if (fifo_count !== 3'd1 || pend_mask !== 32'h80 || reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL mdu_queued: got cnt=%0d mask=%h we=%b, want 1/00000080/0", fifo_count, pend_mask, reg_write);
    end
    tick();
    vectors++;
    if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hDEADBEEF ||
        fifo_count !== 3'd0 || pend_mask !== 32'h80) begin
      miscompares++;
      $display("FAIL mdu_drain: got we=%b reg=%0d data=%h cnt=%0d mask=%h, want 1/7/deadbeef/0/00000080",
               reg_write, write_reg, write_data, fifo_count, pend_mask);
    end
    tick();
    vectors++;
    if (reg_write !== 1'b0 || pend_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL mdu_after: got we=%b mask=%h, want 0/00000000", reg_write, pend_mask);
    end
  endtask

  task automatic test_starve();
    // C0: ALU r10 every cycle, MDU pushes r1..r4 on consecutive edges.
    alu_wr_valid = 1'b1; alu_wr_reg = 5'd10; alu_wr_data = 32'hA0A0A0A0;
    for (int k = 1; k <= 4; k++) begin
      mdu_wr_valid = 1'b1; mdu_wr_reg = 5'(k); mdu_wr_data = 32'h100 + 32'(k);
      tick();
      vectors++;
      if (fifo_count !== 3'(k) || reg_write !== 1'b1 || write_reg !== 5'd10) begin
        miscompares++;
        $display("FAIL starve_fill%0d: got cnt=%0d we=%b reg=%0d, want %0d/1/10",
                 k, fifo_count, reg_write, write_reg, k);
      end
    end
    vectors++;
    if (mdu_wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_full: got ready=%b, want 0", mdu_wr_ready);
    end
    // C4: offer a 5th entry while full.
    mdu_wr_valid = 1'b1; mdu_wr_reg = 5'd5; mdu_wr_data = 32'h105;
    tick();
    mdu_wr_valid = 1'b0;
    vectors++;
    if (fifo_count !== 3'd4 || pend_mask !== 32'h0000041E) begin
      miscompares++;
      $display("FAIL starve_refuse: got cnt=%0d mask=%h, want 4/0000041e", fifo_count, pend_mask);
    end
    // C5..C8: ALU keeps winning, no stall yet.
    for (int c = 5; c <= 8; c++) begin
      vectors++;
      if (alu_stall !== 1'b0 || write_reg !== 5'd10) begin
        miscompares++;
        $display("FAIL starve_c%0d: got stall=%b reg=%0d, want 0/10", c, alu_stall, write_reg);
      end
      tick();
    end
    // C9: forced stall, head pops.
    vectors++;
    if (alu_stall !== 1'b1 || write_reg !== 5'd10) begin
      miscompares++;
      $display("FAIL starve_stall: got stall=%b reg=%0d, want 1/10", alu_stall, write_reg);
    end
    tick();
    idle();
    vectors++;
    if (alu_stall !== 1'b0 || reg_write !== 1'b1 || write_reg !== 5'd1 || write_data !== 32'h101 ||
        fifo_count !== 3'd3) begin
      miscompares++;
      $display("FAIL starve_r1: got stall=%b we=%b reg=%0d data=%h cnt=%0d, want 0/1/1/00000101/3",
               alu_stall, reg_write, write_reg, write_data, fifo_count);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      vectors++;
      if (reg_write !== 1'b1 || write_reg !== 5'(k) || write_data !== 32'h100 + 32'(k)) begin
        miscompares++;
        $display("FAIL starve_r%0d: got we=%b reg=%0d data=%h, want 1/%0d/%h",
                 k, reg_write, write_reg, write_data, k, 32'h100 + 32'(k));
      end
    end
    tick();
    vectors++;
    if (reg_write !== 1'b0 || fifo_count !== 3'd0 || pend_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL starve_end: got we=%b cnt=%0d mask=%h, want 0/0/00000000", reg_write, fifo_count, pend_mask);
    end
  endtask

  task automatic test_zero_reg();
    mdu_wr_valid = 1'b1; mdu_wr_reg = 5'd0; mdu_wr_data = 32'h0BAD0BAD;
    vectors++;
    if (mdu_wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: got ready=%b, want 1", mdu_wr_ready);
    end
    tick();
    idle();
    vectors++;
    if (fifo_count !== 3'd0 || reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_mdu: got cnt=%0d we=%b, want 0/0", fifo_count, reg_write);
    end
    tick();
    vectors++;
    if (reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_mdu_late: got we=%b, want 0", reg_write);
    end
    mdu_wr_valid = 1'b1; mdu_wr_reg = 5'd9; mdu_wr_data = 32'h99999999;
    tick();
    idle();
    alu_wr_valid = 1'b1; alu_wr_reg = 5'd0; alu_wr_data = 32'h55555555;
    tick();
    idle();
    vectors++;
    if (reg_write !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h99999999 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL zero_alu: got we=%b reg=%0d data=%h cnt=%0d, want 1/9/99999999/0",
               reg_write, write_reg, write_data, fifo_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_wr_valid = 1'b1; alu_wr_reg = 5'd11; alu_wr_data = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      mdu_wr_valid = 1'b1; mdu_wr_reg = 5'd12 + 5'(k); mdu_wr_data = 32'hC00 + 32'(k);
      tick();
    end
    idle();
    vectors++;
    if (fifo_count !== 3'd3 || reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: got cnt=%0d we=%b, want 3/1", fifo_count, reg_write);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (reg_write !== 1'b0 || fifo_count !== 3'd0 || pend_mask !== 32'd0 || mdu_wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_now: got we=%b cnt=%0d mask=%h rdy=%b, want 0/0/00000000/1",
               reg_write, fifo_count, pend_mask, mdu_wr_ready);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (reg_write !== 1'b0 || fifo_count !== 3'd0) begin
        miscompares++;
        $display("FAIL rstmid_post%0d: got we=%b cnt=%0d, want 0/0", c, reg_write, fifo_count);
      end
    end
  endtask

  task automatic test_wrap();
    int got;
    int max_cnt;
    got = 0;
    max_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (reg_write === 1'b1) begin
        vectors++;
        if (got >= 10 || write_reg !== 5'd16 + 5'(got) || write_data !== 32'hC0 + 32'(got)) begin
          miscompares++;
          $display("FAIL wrap_out%0d: got reg=%0d data=%h, want %0d/%h",
                   got, write_reg, write_data, 16 + got, 32'hC0 + 32'(got));
        end
        got++;
      end
      if (c < 10) begin
        mdu_wr_valid = 1'b1; mdu_wr_reg = 5'd16 + 5'(c); mdu_wr_data = 32'hC0 + 32'(c);
      end else begin
        mdu_wr_valid = 1'b0;
      end
      tick();
    end
    vectors++;
    if (got != 10) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d writes, want 10", got);
    end
    vectors++;
    if (max_cnt > 2 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL wrap_occ: got max=%0d final=%0d, want <=2/0", max_cnt, fifo_count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    rst = 1'b1;
    test_reset();
    test_alu_write();
    test_mdu_write();
    test_starve();
    test_zero_reg();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
